// File: rtl/debug_line_tokenizer.sv
// rtl/debug_line_tokenizer.sv - splits RS-232 command lines into space-separated tokens
`timescale 1ns/100ps
module debug_line_tokenizer #(
  parameter int MAX_ARGS  = 4,
  parameter int ARG_CHARS = 10
) (
  input  logic                            MainCLK,
  input  logic                            RST_N,
  input  logic [7:0]                      RXData,
  input  logic                            RXValid,
  input  logic                            LINE_ACK,
  output logic [MAX_ARGS*ARG_CHARS*8-1:0] ARGS,
  output logic [2:0]                      ARGC,
  output logic                            LINE_VALID,
  output logic                            ERR,
  output logic                            DROPPED,
  output logic [7:0]                      ECHO_DATA,
  output logic                            ECHO_VALID
);

  localparam int TW    = ARG_CHARS * 8;
  localparam int LEN_W = $clog2(ARG_CHARS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(ARG_CHARS);
  localparam logic [2:0]       MAX_ARGC = 3'(MAX_ARGS);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DISCARD = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] len;
  logic [TW-1:0]    cur_tok;
  int               tok_base;
  logic             is_print, is_space, is_cr, is_bs, is_ignored;

  // Once ARGC reaches MAX_ARGS there is no open token; point at slot 0 to keep the read in range.
  always_comb begin
    tok_base = (ARGC < MAX_ARGC) ? int'(ARGC) * TW : 0;
    cur_tok  = ARGS[tok_base +: TW];
  end

  assign is_print   = (RXData >= 8'h21) && (RXData <= 8'h7E);
  assign is_space   = (RXData == 8'h20);
  assign is_cr      = (RXData == 8'h0D);
  assign is_bs      = (RXData == 8'h08) || (RXData == 8'h7F);
  assign is_ignored = (RXData < 8'h20) && !is_cr && !is_bs;

  always_ff @(posedge MainCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= COLLECT;
      len        <= '0;
      ARGS       <= '0;
      ARGC       <= '0;
      LINE_VALID <= 1'b0;
      ERR        <= 1'b0;
      DROPPED    <= 1'b0;
      ECHO_DATA  <= '0;
      ECHO_VALID <= 1'b0;
    end else begin
      ERR        <= 1'b0;
      DROPPED    <= 1'b0;
      ECHO_VALID <= 1'b0;
      case (state)
        HOLD: begin
          // LF trailing a CR is expected from terminals and must not count as a lost byte.
          if (RXValid && !is_ignored) DROPPED <= 1'b1;
          if (LINE_ACK) begin
            LINE_VALID <= 1'b0;
            ARGS       <= '0;
            ARGC       <= '0;
            len        <= '0;
            state      <= COLLECT;
          end
        end
        DISCARD: begin
          if (RXValid) begin
            ECHO_VALID <= 1'b1;
            ECHO_DATA  <= RXData;
            if (is_cr) begin
              ARGS  <= '0;
              ARGC  <= '0;
              len   <= '0;
              ERR   <= 1'b1;
              state <= COLLECT;
            end
          end
        end
        default: begin
          if (RXValid) begin
            ECHO_VALID <= 1'b1;
            ECHO_DATA  <= RXData;
            if (is_print) begin
              if ((len < MAX_LEN) && (ARGC < MAX_ARGC)) begin
                ARGS[tok_base +: TW] <= {cur_tok[TW-9:0], RXData};
                len                  <= len + LEN_W'(1);
              end else begin
                state <= DISCARD;
              end
            end else if (is_space) begin
              if (len != '0) begin
                ARGC <= ARGC + 3'd1;
                len  <= '0;
              end
            end else if (is_cr) begin
              if ((len != '0) || (ARGC != '0)) begin
                if (len != '0) ARGC <= ARGC + 3'd1;
                len        <= '0;
                LINE_VALID <= 1'b1;
                state      <= HOLD;
              end else begin
                ARGS <= '0;
              end
            end else if (is_bs) begin
              if (len != '0) begin
                ARGS[tok_base +: TW] <= {8'h00, cur_tok[TW-1:8]};
                len                  <= len - LEN_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/debug_line_tokenizer.md
DEBUG_LINE_TOKENIZER -- requirements
Module: debug_line_tokenizer

Interface
REQ-001 Parameter MAX_ARGS, default 4, maximum number of tokens per line.
REQ-002 Parameter ARG_CHARS, default 10, maximum characters per token.
REQ-003 MainCLK  input  1  the only clock; all state changes occur on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 RXData  input  8  received byte from the RS-232 receiver.
REQ-006 RXValid  input  1  one-cycle strobe; RXData is valid in that cycle.
REQ-007 LINE_ACK  input  1  consumer has read the line; releases the hold.
REQ-008 ARGS  output  MAX_ARGS*ARG_CHARS*8  packed tokens.
- Token k occupies bits [k*ARG_CHARS*8 +: ARG_CHARS*8].
REQ-009 ARGC  output  3  number of complete tokens in ARGS.
REQ-010 LINE_VALID  output  1  a line is ready; held high until acknowledged.
REQ-011 ERR  output  1  one-cycle pulse when an overflowed line is discarded.
REQ-012 DROPPED  output  1  one-cycle pulse when a byte is lost while LINE_VALID is high.
REQ-013 ECHO_DATA  output  8  byte to echo back to the terminal.
REQ-014 ECHO_VALID  output  1  one-cycle strobe for ECHO_DATA.

Function
REQ-015 The block SHALL have three states: COLLECT, DISCARD and HOLD; it leaves reset in COLLECT.
REQ-016 Token packing SHALL make a token compare equal to a zero-extended Verilog string literal.
- Each new character shifts the token left by 8 bits and enters at the LSB byte.
- Unused upper bytes are zero.
REQ-017 COLLECT, printable byte (0x21-0x7E), current token length < ARG_CHARS and ARGC < MAX_ARGS: the byte SHALL be appended to token ARGC.
REQ-018 COLLECT, printable byte, token already ARG_CHARS long or ARGC == MAX_ARGS: the block SHALL enter DISCARD; the byte is not stored.
REQ-019 COLLECT, space (0x20) with a non-empty current token: the token SHALL close (ARGC+1, length counter cleared).
- A space with an empty current token is ignored, so leading and repeated spaces collapse.
REQ-020 COLLECT, CR (0x0D): the current token SHALL close if non-empty.
- If ARGC ends up >= 1, the block enters HOLD and LINE_VALID goes high on the same edge.
- Otherwise (empty line) all state is cleared and the block stays in COLLECT.
REQ-021 COLLECT, backspace (0x08 or 0x7F) with a non-empty current token: the token SHALL shift right 8 bits and its length decrement.
- With an empty current token it has no effect; a closed token is never reopened.
REQ-022 LF (0x0A) and all other control bytes SHALL be ignored in every state.
REQ-023 DISCARD: all bytes except CR SHALL be ignored.
- CR clears ARGS, ARGC and the counters, pulses ERR for one cycle and returns to COLLECT; LINE_VALID stays low.
REQ-024 HOLD: ARGS and ARGC SHALL be stable.
- Any RXValid pulses DROPPED for one cycle, and the byte is neither stored nor echoed.
REQ-025 HOLD with LINE_ACK high: on that edge LINE_VALID SHALL go low, ARGS, ARGC and the counters clear, and the block enters COLLECT.
- A byte arriving in the same cycle is dropped and DROPPED pulses.
REQ-026 LINE_ACK outside HOLD SHALL have no effect.
REQ-027 Every RXValid byte accepted in COLLECT or DISCARD SHALL be registered to ECHO_DATA, with ECHO_VALID high for exactly one cycle starting on the sampling edge.
- This includes spaces, CR, LF and backspace.
REQ-028 Latency: all outputs SHALL update on the same edge that samples RXValid; there is no combinational path from inputs to outputs.
REQ-029 The character-length counter SHALL be ceil(log2(ARG_CHARS+1)) bits and SHALL never wrap.

Reset
REQ-030 While RST_N is low, the following SHALL be cleared immediately regardless of MainCLK:
- ARGS = 0, ARGC = 0, LINE_VALID = 0, ERR = 0, DROPPED = 0, ECHO_VALID = 0, ECHO_DATA = 0.
- State = COLLECT, all counters = 0.
REQ-031 Reset asserted mid-line or in HOLD SHALL discard the partial or held line; after release the next byte starts a fresh line.

Verification
REQ-032 "get IN3\r" -> LINE_VALID=1, ARGC=2, token0 = 0x676574 (upper bytes 0), token1 = "IN3"; ECHO_VALID pulses 8 times.
REQ-033 "  set  OUT1 to 255\r\n" -> ARGC=4, token3 = "255"; LF causes no DROPPED pulse because it arrives after CR while LINE_VALID is high.
REQ-034 "helpmeeeeee\r" (11 chars) -> LINE_VALID stays 0, ERR pulses once on the CR edge, ARGS = 0 afterwards; "a b c d e\r" also produces ERR.
REQ-035 "hx", 0x08, "elp\r" -> ARGC=1, token0 = "help".
REQ-036 Line held; "z" sent with LINE_ACK high in the same cycle -> DROPPED pulses once, LINE_VALID falls, then "vars\r" yields ARGC=1, token0 = "vars".
REQ-037 "set OU" followed by RST_N low for 1 ns between edges -> outputs clear asynchronously; then "help\r" yields ARGC=1, token0 = "help".
